// File: rtl/prco_ctrl_sched_pkg.sv
// Shared types for the PRCO control sequencer: state encoding and timeout counter width.
package prco_ctrl_sched_pkg;

    localparam int PRCO_CTRL_TO_W = 4;

    typedef enum logic [2:0] {
        PRCO_CS_IDLE   = 3'd0,
        PRCO_CS_FETCH  = 3'd1,
        PRCO_CS_DECODE = 3'd2,
        PRCO_CS_DWAIT  = 3'd3,
        PRCO_CS_EXEC   = 3'd4,
        PRCO_CS_MEM    = 3'd5,
        PRCO_CS_WB     = 3'd6
    } prco_cs_e;

endpackage

// File: rtl/prco_ctrl_sched.sv
// PRCO instruction sequencer and single-port RAM arbiter (fetch vs LW/SW data access).
// Optional memory ack timeout is enabled by defining PRCO_CTRL_TIMEOUT_EN.
module prco_ctrl_sched
    import prco_ctrl_sched_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    output logic [15:0]       q_instr,
    output logic              q_dec_ce,
    input  logic              i_dec_ce,
    input  logic              i_dec_fetch,
    input  logic              i_req_ram,
    input  logic              i_req_ram_we,
    input  logic              i_reg_we,
    input  logic [ADDR_W-1:0] i_data_addr,
    output logic              q_mem_req,
    output logic              q_mem_we,
    output logic [ADDR_W-1:0] q_mem_addr,
    input  logic              i_mem_ack,
    input  logic [15:0]       i_mem_rdata,
    output logic              q_alu_ce,
    output logic              q_reg_we_stb,
    output logic [ADDR_W-1:0] q_pc,
    output logic              q_busy,
    output logic              q_err
);

    prco_cs_e          r_state;
    prco_cs_e          w_next;
    prco_cs_e          w_park;
    logic              r_mem_we_lat;
    logic              r_reg_we_lat;
    logic              w_ack;
    logic              w_timeout;
    logic              w_dec_exit;
    logic              w_we_next;
    logic [ADDR_W-1:0] w_pc_next;

    // Acks outside an active request are ignored by construction.
    assign w_ack      = i_mem_ack & q_mem_req;
    assign w_park     = i_en ? PRCO_CS_FETCH : PRCO_CS_IDLE;
    assign w_dec_exit = (r_state == PRCO_CS_DWAIT) & i_dec_ce & ~i_dec_fetch;
    assign w_we_next  = (r_state == PRCO_CS_DWAIT) ? i_req_ram_we : r_mem_we_lat;
    assign w_pc_next  = (r_state == PRCO_CS_FETCH && w_ack) ? q_pc + ADDR_W'(1) : q_pc;

`ifdef PRCO_CTRL_TIMEOUT_EN
    localparam logic [PRCO_CTRL_TO_W-1:0] LP_TO_LAST = PRCO_CTRL_TO_W'(MEM_TIMEOUT - 1);

    logic [PRCO_CTRL_TO_W-1:0] r_to_cnt;

    assign w_timeout = q_mem_req & ~i_mem_ack & (r_to_cnt == LP_TO_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_to_cnt <= '0;
            q_err    <= 1'b0;
        end else begin
            q_err <= w_timeout;
            if (w_timeout || w_next != r_state)
                r_to_cnt <= '0;
            else if (q_mem_req)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign q_err     = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= PRCO_CS_IDLE;
        else          r_state <= w_next;
    end

    // NOTE: w_next gets its default first, so no path through the case can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            PRCO_CS_IDLE:   if (i_en) w_next = PRCO_CS_FETCH;
            PRCO_CS_FETCH:  if (w_ack) w_next = PRCO_CS_DECODE;
            PRCO_CS_DECODE: w_next = PRCO_CS_DWAIT;
            PRCO_CS_DWAIT: begin
                if (i_dec_fetch)   w_next = w_park;
                else if (i_dec_ce) w_next = i_req_ram ? PRCO_CS_MEM : PRCO_CS_EXEC;
            end
            PRCO_CS_EXEC:   w_next = PRCO_CS_WB;
            PRCO_CS_MEM:    if (w_ack) w_next = r_mem_we_lat ? w_park : PRCO_CS_WB;
            PRCO_CS_WB:     w_next = w_park;
            default:        w_next = PRCO_CS_IDLE;
        endcase
        if (w_timeout) w_next = PRCO_CS_FETCH;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            q_pc         <= RESET_PC;
            q_instr      <= '0;
            q_dec_ce     <= 1'b0;
            q_alu_ce     <= 1'b0;
            q_reg_we_stb <= 1'b0;
            q_mem_req    <= 1'b0;
            q_mem_we     <= 1'b0;
            q_mem_addr   <= '0;
            q_busy       <= 1'b0;
            r_mem_we_lat <= 1'b0;
            r_reg_we_lat <= 1'b0;
        end else begin
            q_pc         <= w_pc_next;
            q_busy       <= (w_next != PRCO_CS_IDLE);
            q_dec_ce     <= (w_next == PRCO_CS_DECODE);
            q_alu_ce     <= (w_next == PRCO_CS_EXEC);
            q_reg_we_stb <= (w_next == PRCO_CS_WB) & r_reg_we_lat;
            q_mem_req    <= (w_next == PRCO_CS_FETCH || w_next == PRCO_CS_MEM) & ~w_timeout;
            q_mem_we     <= (w_next == PRCO_CS_MEM) & w_we_next;

            if (r_state == PRCO_CS_FETCH && w_ack)
                q_instr <= i_mem_rdata;

            // The data address is captured on MEM entry and held until the ack.
            if (w_next == PRCO_CS_FETCH)
                q_mem_addr <= w_pc_next;
            else if (w_next == PRCO_CS_MEM && r_state == PRCO_CS_DWAIT)
                q_mem_addr <= i_data_addr;
            else if (w_next != PRCO_CS_MEM)
                q_mem_addr <= '0;

            if (w_dec_exit) begin
                r_mem_we_lat <= i_req_ram & i_req_ram_we;
                r_reg_we_lat <= i_reg_we;
            end
        end
    end

endmodule

// File: tb/tb_prco_ctrl_sched.sv
// Randomized bench for prco_ctrl_sched: per-cycle stimulus and expected outputs are built
// together from instruction-level rules, then replayed and compared every cycle.
module tb_prco_ctrl_sched;

    localparam logic [15:0] RST_PC = 16'hFFFE;
`ifdef PRCO_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_en;
    logic [15:0] q_instr;
    logic        q_dec_ce;
    logic        i_dec_ce;
    logic        i_dec_fetch;
    logic        i_req_ram;
    logic        i_req_ram_we;
    logic        i_reg_we;
    logic [15:0] i_data_addr;
    logic        q_mem_req;
    logic        q_mem_we;
    logic [15:0] q_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;
    logic        q_alu_ce;
    logic        q_reg_we_stb;
    logic [15:0] q_pc;
    logic        q_busy;
    logic        q_err;

    always #5 i_clk = ~i_clk;

    prco_ctrl_sched #(.ADDR_W(16), .RESET_PC(RST_PC), .MEM_TIMEOUT(15)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en),
        .q_instr(q_instr), .q_dec_ce(q_dec_ce),
        .i_dec_ce(i_dec_ce), .i_dec_fetch(i_dec_fetch),
        .i_req_ram(i_req_ram), .i_req_ram_we(i_req_ram_we), .i_reg_we(i_reg_we),
        .i_data_addr(i_data_addr),
        .q_mem_req(q_mem_req), .q_mem_we(q_mem_we), .q_mem_addr(q_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .q_alu_ce(q_alu_ce), .q_reg_we_stb(q_reg_we_stb),
        .q_pc(q_pc), .q_busy(q_busy), .q_err(q_err)
    );

    typedef enum int {K_ADD, K_LW, K_SW, K_NOP} kind_e;

    typedef struct {
        bit          en, ack, dce, dfetch, rram, rwe, rgwe;
        logic [15:0] rdata, daddr;
    } drv_t;

    typedef struct {
        bit          req, we, dce, alu, rws, busy, err;
        logic [15:0] addr, pc, instr;
        int          lit;
    } exp_t;

    drv_t        drv_q[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    int          pending_lit = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic drv_t noise();
        drv_t d;
        d.en = 1'($urandom); d.ack = 1'($urandom); d.dce = 1'($urandom);
        d.dfetch = 1'($urandom); d.rram = 1'($urandom); d.rwe = 1'($urandom);
        d.rgwe = 1'($urandom); d.rdata = 16'($urandom); d.daddr = 16'($urandom);
        return d;
    endfunction

    function automatic exp_t base(bit busy);
        exp_t e;
        e.req = 0; e.we = 0; e.dce = 0; e.alu = 0; e.rws = 0; e.err = 0;
        e.busy = busy; e.addr = 16'h0; e.pc = m_pc; e.instr = m_instr; e.lit = 0;
        return e;
    endfunction

    function automatic void push(drv_t d, exp_t e);
        e.lit = pending_lit;
        pending_lit = 0;
        drv_q.push_back(d);
        exp_q.push_back(e);
    endfunction

    function automatic void gen_idle(int n);
        for (int i = 0; i < n; i++) begin
            drv_t d = noise();
            d.en = (i == n - 1);
            push(d, base(0));
        end
    endfunction

    // Fifteen unanswered request cycles, then one request-free cycle carrying the error pulse.
    function automatic void gen_timeout();
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            drv_t d = noise();
            d.ack = 0;
            e = base(1); e.req = 1; e.addr = m_pc;
            push(d, e);
        end
        e = base(1); e.err = 1;
        push(noise(), e);
    endfunction

    function automatic void gen_fetch(int fw);
        for (int i = 0; i <= fw; i++) begin
            drv_t d = noise();
            exp_t e = base(1);
            d.ack = (i == fw);
            e.req = 1; e.addr = m_pc;
            push(d, e);
            if (i == fw) begin
                m_instr = d.rdata;
                m_pc    = m_pc + 16'd1;
            end
        end
    endfunction

    function automatic void gen_instr(kind_e k, int fw, int dd, int mw, int rgw, bit park,
                                      logic [15:0] daddr, bit to);
        drv_t d;
        exp_t e;
        bit   reg_we;
        if (to) gen_timeout();
        gen_fetch(fw);
        e = base(1); e.dce = 1;
        push(noise(), e);
        for (int i = 0; i < dd; i++) begin
            d = noise(); d.dce = 0; d.dfetch = 0;
            push(d, base(1));
        end
        d = noise();
        if (rgw >= 0) d.rgwe = rgw[0];
        reg_we = d.rgwe;
        d.daddr = daddr;
        case (k)
            K_NOP: begin d.dfetch = 1; d.en = !park; end
            K_ADD: begin d.dfetch = 0; d.dce = 1; d.rram = 0; end
            K_LW:  begin d.dfetch = 0; d.dce = 1; d.rram = 1; d.rwe = 0; end
            default: begin d.dfetch = 0; d.dce = 1; d.rram = 1; d.rwe = 1; end
        endcase
        push(d, base(1));
        if (k == K_ADD) begin
            e = base(1); e.alu = 1;
            push(noise(), e);
        end
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mw; i++) begin
                d = noise();
                d.ack = (i == mw);
                if (i == mw && k == K_SW) d.en = !park;
                e = base(1); e.req = 1; e.we = (k == K_SW); e.addr = daddr;
                push(d, e);
            end
        end
        if (k == K_ADD || k == K_LW) begin
            d = noise(); d.en = !park;
            e = base(1); e.rws = reg_we;
            push(d, e);
        end
    endfunction

    task automatic apply(input drv_t d);
        i_en = d.en; i_mem_ack = d.ack; i_dec_ce = d.dce; i_dec_fetch = d.dfetch;
        i_req_ram = d.rram; i_req_ram_we = d.rwe; i_reg_we = d.rgwe;
        i_mem_rdata = d.rdata; i_data_addr = d.daddr;
    endtask

    function automatic logic [63:0] pack_exp(exp_t e);
        return {9'b0, e.req, e.we, e.dce, e.alu, e.rws, e.busy, e.err,
                e.pc, e.instr, (e.req ? e.addr : 16'h0)};
    endfunction

    function automatic logic [63:0] pack_act();
        return {9'b0, q_mem_req, q_mem_we, q_dec_ce, q_alu_ce, q_reg_we_stb, q_busy, q_err,
                q_pc, q_instr, (q_mem_req ? q_mem_addr : 16'h0)};
    endfunction

    initial begin
        int n;
        int cnt_dce = 0, cnt_alu = 0, cnt_rws = 0, cnt_we = 0;
        i_reset = 1'b0;
        apply('{default: 0});
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_pc", 64'(q_pc), 64'(16'hFFFE));
        check("reset_outs", 64'(pack_act()), 64'({16'hFFFE, 16'h0, 16'h0}));
        @(negedge i_clk);
        i_reset = 1'b1;

        m_pc = RST_PC;
        m_instr = 16'h0;
        gen_idle(1);
        gen_instr(K_LW, 0, 0, 3, 1, 0, 16'h0040, 0);
        gen_instr(K_NOP, 0, 1, 0, -1, 0, 16'h0, 0);
        pending_lit = 1;
        gen_instr(K_ADD, 1, 0, 0, 1, 0, 16'h0, 0);
        pending_lit = 2;
        gen_instr(K_SW, 0, 0, 2, -1, 1, 16'h1234, 0);
        pending_lit = 3;
        gen_idle(2);
        for (int i = 0; i < 150; i++) begin
            bit park = ($urandom_range(0, 7) == 0);
            bit to   = TO_EN && ($urandom_range(0, 15) == 0);
            gen_instr(kind_e'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 3), -1, park, 16'($urandom), to);
            if (park) gen_idle($urandom_range(1, 3));
        end
        // Final SW stalls in its data phase; its ack cycle is removed so reset lands mid-MEM.
        gen_instr(K_SW, 0, 0, 4, -1, 0, 16'h0BEE, 0);
        void'(drv_q.pop_back());
        void'(exp_q.pop_back());
        n = drv_q.size();

        fork
            begin
                for (int c = 0; c < n; c++) begin
                    @(posedge i_clk);
                    #1;
                    apply(drv_q[c]);
                end
            end
            begin
                for (int c = 0; c < n; c++) begin
                    @(posedge i_clk);
                    @(negedge i_clk);
                    check($sformatf("cycle%0d", c), pack_act(), pack_exp(exp_q[c]));
                    if (exp_q[c].lit == 1) check("wrap_pc", 64'(q_pc), 64'(16'h0000));
                    if (exp_q[c].lit == 2) check("add_pc", 64'(q_pc), 64'(16'h0001));
                    if (exp_q[c].lit == 3) begin
                        check("dir_dec_pulses", 64'(cnt_dce), 64'd4);
                        check("dir_alu_pulses", 64'(cnt_alu), 64'd1);
                        check("dir_rws_pulses", 64'(cnt_rws), 64'd2);
                        check("dir_we_cycles", 64'(cnt_we), 64'd3);
                        check("dir_end_pc", 64'(q_pc), 64'(16'h0002));
                    end
                    cnt_dce += int'(q_dec_ce);
                    cnt_alu += int'(q_alu_ce);
                    cnt_rws += int'(q_reg_we_stb);
                    cnt_we  += int'(q_mem_we);
                end
            end
        join

        @(posedge i_clk);
        #1;
        check("sw_pending", 64'({q_mem_req, q_mem_we, q_mem_addr}), 64'({2'b11, 16'h0BEE}));
        #2 i_reset = 1'b0;
        #1;
        check("mid_mem_reset", 64'(pack_act()), 64'({16'hFFFE, 16'h0, 16'h0}));
        repeat (3) begin
            @(negedge i_clk);
            check("reset_hold_we", 64'({q_mem_we, q_mem_req, q_busy}), 64'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
